// File: rtl/broadcaster_masked_fifo.sv
// Masked broadcaster: one input transaction is copied into any subset of SIZE
// per-channel FIFOs. A stalled channel only blocks transactions that target it.
module broadcaster_masked_fifo #(
   parameter int    SIZE   = 8,
   parameter int    WIDTH  = 32,
   parameter int    DEPTH  = 4,
   parameter string SHARED = "yes"
) (
   input  logic                                          iCLK,
   input  logic                                          iRST,
   input  logic                                          iValid_AM,
   output logic                                          oReady_AM,
   input  logic [SIZE-1:0]                               iMask_AM,
   input  logic [((SHARED == "yes") ? WIDTH : SIZE*WIDTH)-1:0] iData_AM,
   output logic [SIZE-1:0]                               oValid_BM,
   input  logic [SIZE-1:0]                               iReady_BM,
   output logic [SIZE*WIDTH-1:0]                         oData_BM,
   output logic [SIZE*($clog2(DEPTH)+1)-1:0]             oLevel_BM
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [SIZE-1:0] full;
   logic            acc;

   // Ready looks only at registered fullness, so a same-cycle pop never frees a slot.
   assign oReady_AM = &(~iMask_AM | ~full);
   assign acc       = iValid_AM & oReady_AM;

   for (genvar gi = 0; gi < SIZE; gi++) begin : g_ch
      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
      logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
      logic [CW-1:0]    count_q, count_d;
      logic [WIDTH-1:0] din;
      logic             push;
      logic             pop;

      if (SHARED == "yes") begin : g_shared
         assign din = iData_AM[WIDTH-1:0];
      end else begin : g_sliced
         assign din = iData_AM[gi*WIDTH +: WIDTH];
      end

      assign full[gi] = (count_q == FULL_CNT);
      assign push     = acc & iMask_AM[gi];
      assign pop      = (count_q != '0) & iReady_BM[gi];

      always_comb begin
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = rd_ptr_q;
         count_d  = count_q;
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end

      always_ff @(posedge iCLK) begin
         if (iRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
         end
      end

      // Storage is not reset; a word only becomes visible through count.
      always_ff @(posedge iCLK) begin
         if (push && !iRST) mem_q[wr_ptr_q] <= din;
      end

      assign oValid_BM[gi]               = (count_q != '0);
      assign oData_BM[gi*WIDTH +: WIDTH] = mem_q[rd_ptr_q];
      assign oLevel_BM[gi*CW +: CW]      = count_q;
   end

endmodule

// File: tb/tb_broadcaster_masked_fifo.sv
// Bench for broadcaster_masked_fifo: a shared-data and a sliced-data instance
// run in lockstep against per-channel expected-word queues.
module tb_broadcaster_masked_fifo;
   localparam int SIZE  = 4;
   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int LW    = 3;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  valid;
   logic                  ready_s, ready_n;
   logic [SIZE-1:0]       mask;
   logic [SIZE-1:0]       rdy_b;
   logic [SIZE-1:0]       ovalid_s, ovalid_n;
   logic [WIDTH-1:0]      data_s;
   logic [SIZE*WIDTH-1:0] data_n;
   logic [SIZE*WIDTH-1:0] odata_s, odata_n;
   logic [SIZE*LW-1:0]    level_s, level_n;

   logic [WIDTH-1:0] sbq [SIZE][$];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Sliced instance gets channel g's word offset by g*0x100.
   always_comb begin
      data_n = '0;
      for (int g = 0; g < SIZE; g++) data_n[g*WIDTH +: WIDTH] = data_s + WIDTH'(g * 256);
   end

   broadcaster_masked_fifo #(.SIZE(SIZE), .WIDTH(WIDTH), .DEPTH(DEPTH), .SHARED("yes")) dut_s (
      .iCLK(clk), .iRST(rst), .iValid_AM(valid), .oReady_AM(ready_s), .iMask_AM(mask),
      .iData_AM(data_s), .oValid_BM(ovalid_s), .iReady_BM(rdy_b), .oData_BM(odata_s),
      .oLevel_BM(level_s));

   broadcaster_masked_fifo #(.SIZE(SIZE), .WIDTH(WIDTH), .DEPTH(DEPTH), .SHARED("no")) dut_n (
      .iCLK(clk), .iRST(rst), .iValid_AM(valid), .oReady_AM(ready_n), .iMask_AM(mask),
      .iData_AM(data_n), .oValid_BM(ovalid_n), .iReady_BM(rdy_b), .oData_BM(odata_n),
      .oLevel_BM(level_n));

   function automatic logic [LW-1:0] lvl(input int g);
      return level_s[g*LW +: LW];
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: pop/compare on each output handshake, push on each input accept.
   always @(negedge clk) begin
      if (rst) begin
         for (int g = 0; g < SIZE; g++) sbq[g].delete();
      end else begin
         total++;
         if (ovalid_n !== ovalid_s || ready_n !== ready_s || level_n !== level_s) begin
            bad++;
            $display("FAIL mode_match valid_n=%h valid_s=%h ready_n=%b ready_s=%b", ovalid_n, ovalid_s, ready_n, ready_s);
         end
         for (int g = 0; g < SIZE; g++) begin
            if (ovalid_s[g] && rdy_b[g]) begin
               total++;
               if (sbq[g].size() == 0) begin
                  bad++;
                  $display("FAIL ch%0d_unexpected got=%h want=nothing", g, odata_s[g*WIDTH +: WIDTH]);
               end else begin
                  logic [WIDTH-1:0] exp;
                  exp = sbq[g].pop_front();
                  if (odata_s[g*WIDTH +: WIDTH] !== exp ||
                      odata_n[g*WIDTH +: WIDTH] !== exp + WIDTH'(g * 256)) begin
                     bad++;
                     $display("FAIL ch%0d_data got_s=%h got_n=%h want_s=%h", g,
                              odata_s[g*WIDTH +: WIDTH], odata_n[g*WIDTH +: WIDTH], exp);
                  end
               end
            end
         end
         if (valid && ready_s)
            for (int g = 0; g < SIZE; g++) if (mask[g]) sbq[g].push_back(data_s);
      end
   end

   task automatic test_reset();
      rst = 1'b1; valid = 1'b1; mask = '1; data_s = 32'hDEAD_BEEF; rdy_b = '1;
      next_cycle();
      next_cycle();
      rst = 1'b0; valid = 1'b0;
      @(negedge clk);
      total++;
      if (ovalid_s !== 4'h0 || level_s !== '0 || ready_s !== 1'b1) begin
         bad++;
         $display("FAIL reset_state valid=%h level=%h ready=%b want 0/0/1", ovalid_s, level_s, ready_s);
      end
      next_cycle();
      next_cycle();
      @(negedge clk);
      total++;
      if (ovalid_s !== 4'h0) begin
         bad++;
         $display("FAIL reset_nowrite valid=%h want 0", ovalid_s);
      end
      next_cycle();
   endtask

   task automatic test_back_to_back();
      rdy_b = '1; mask = 4'hF;
      for (int i = 0; i < 16; i++) begin
         valid = 1'b1; data_s = 32'h10 + WIDTH'(i);
         @(negedge clk);
         total++;
         if (ready_s !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready word=%0d got=%b want=1", i, ready_s);
         end
         total++;
         if (i == 0) begin
            if (ovalid_s !== 4'h0) begin
               bad++;
               $display("FAIL b2b_first_valid got=%h want=0", ovalid_s);
            end
         end else if (ovalid_s !== 4'hF || level_s !== {SIZE{3'd1}}) begin
            bad++;
            $display("FAIL b2b_stream word=%0d valid=%h level=%h want F/%h", i, ovalid_s, level_s, {SIZE{3'd1}});
         end
         next_cycle();
      end
      valid = 1'b0;
      @(negedge clk);
      total++;
      if (ovalid_s !== 4'hF || level_s !== {SIZE{3'd1}}) begin
         bad++;
         $display("FAIL b2b_last valid=%h level=%h", ovalid_s, level_s);
      end
      next_cycle();
      @(negedge clk);
      total++;
      if (ovalid_s !== 4'h0 || level_s !== '0) begin
         bad++;
         $display("FAIL b2b_drained valid=%h level=%h want 0/0", ovalid_s, level_s);
      end
      next_cycle();
   endtask

   task automatic test_backpressure();
      rdy_b = 4'b1110; mask = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         valid = 1'b1; data_s = 32'h20 + WIDTH'(i);
         @(negedge clk);
         total++;
         if (ready_s !== 1'b1) begin
            bad++;
            $display("FAIL bp_accept word=%0d ready=%b want=1", i, ready_s);
         end
         next_cycle();
      end
      data_s = 32'h24;
      @(negedge clk);
      total++;
      if (ready_s !== 1'b0 || lvl(0) !== 3'd4 || lvl(2) !== 3'd1) begin
         bad++;
         $display("FAIL bp_full ready=%b lvl0=%0d lvl2=%0d want 0/4/1", ready_s, lvl(0), lvl(2));
      end
      next_cycle();
      @(negedge clk);
      total++;
      if (ready_s !== 1'b0 || lvl(0) !== 3'd4 || lvl(2) !== 3'd0 || ovalid_s !== 4'b0001) begin
         bad++;
         $display("FAIL bp_hold ready=%b lvl0=%0d lvl2=%0d valid=%h want 0/4/0/1", ready_s, lvl(0), lvl(2), ovalid_s);
      end
      next_cycle();
      valid = 1'b0;
   endtask

   task automatic test_other_channel();
      valid = 1'b1; mask = 4'b0010; data_s = 32'h30;
      @(negedge clk);
      total++;
      if (ready_s !== 1'b1) begin
         bad++;
         $display("FAIL other_ready got=%b want=1", ready_s);
      end
      next_cycle();
      valid = 1'b0;
      @(negedge clk);
      total++;
      if (ovalid_s !== 4'b0011 || lvl(1) !== 3'd1 || lvl(0) !== 3'd4) begin
         bad++;
         $display("FAIL other_route valid=%h lvl1=%0d lvl0=%0d want 3/1/4", ovalid_s, lvl(1), lvl(0));
      end
      next_cycle();
      @(negedge clk);
      total++;
      if (ovalid_s !== 4'b0001) begin
         bad++;
         $display("FAIL other_drain valid=%h want=1", ovalid_s);
      end
      next_cycle();
   endtask

   task automatic test_pop_push();
      rdy_b = 4'hF; valid = 1'b1; mask = 4'b0001; data_s = 32'h40;
      @(negedge clk);
      total++;
      if (ready_s !== 1'b0 || lvl(0) !== 3'd4) begin
         bad++;
         $display("FAIL pp_refuse ready=%b lvl0=%0d want 0/4", ready_s, lvl(0));
      end
      next_cycle();
      @(negedge clk);
      total++;
      if (ready_s !== 1'b1 || lvl(0) !== 3'd3) begin
         bad++;
         $display("FAIL pp_retry ready=%b lvl0=%0d want 1/3", ready_s, lvl(0));
      end
      next_cycle();
      valid = 1'b0;
      @(negedge clk);
      total++;
      if (lvl(0) !== 3'd3) begin
         bad++;
         $display("FAIL pp_level lvl0=%0d want 3", lvl(0));
      end
      repeat (4) next_cycle();
      @(negedge clk);
      total++;
      if (ovalid_s !== 4'h0 || sbq[0].size() != 0) begin
         bad++;
         $display("FAIL pp_drain valid=%h left=%0d want 0/0", ovalid_s, sbq[0].size());
      end
      next_cycle();
   endtask

   task automatic test_mask_zero();
      logic prev;
      prev = 1'b0;
      rdy_b = '1;
      for (int i = 0; i < 8; i++) begin
         valid = 1'b1; mask = i[0] ? 4'b1000 : 4'b0000; data_s = 32'h50 + WIDTH'(i);
         @(negedge clk);
         total++;
         if (ready_s !== 1'b1 || ovalid_s !== (prev ? 4'b1000 : 4'b0000)) begin
            bad++;
            $display("FAIL mz_step%0d ready=%b valid=%h want 1/%h", i, ready_s, ovalid_s, prev ? 4'b1000 : 4'b0000);
         end
         prev = mask[3];
         next_cycle();
      end
      valid = 1'b0; mask = '0;
      @(negedge clk);
      total++;
      if (ovalid_s !== (prev ? 4'b1000 : 4'b0000)) begin
         bad++;
         $display("FAIL mz_last valid=%h", ovalid_s);
      end
      next_cycle();
      @(negedge clk);
      total++;
      if (ovalid_s !== 4'h0) begin
         bad++;
         $display("FAIL mz_idle valid=%h want 0", ovalid_s);
      end
      next_cycle();
   endtask

   task automatic test_final_empty();
      repeat (3) next_cycle();
      for (int g = 0; g < SIZE; g++) begin
         total++;
         if (sbq[g].size() != 0) begin
            bad++;
            $display("FAIL final_ch%0d undelivered=%0d want 0", g, sbq[g].size());
         end
      end
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; mask = '0; data_s = '0; rdy_b = '1;
      next_cycle();
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_other_channel();
      test_pop_push();
      test_mask_zero();
      test_final_empty();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
